// File: rtl/cn_q_monitor.sv
// cn_q_monitor
//   Watches the q/qbar pair of cn_flipflop every clock. Flags a sticky error
//   when the pair is not complementary, tracks the output level with a
//   three-state FSM, counts rising/falling transitions, measures run lengths
//   and flags an output that has stayed at one level too long.
//
// Parameters
//   CNT_W        width of transition counters and run-length registers
//   STUCK_LIMIT  run length (samples) at which stuck asserts, 2..2^CNT_W-1
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   q_in        q output of cn_flipflop
//   qbar_in     qbar output of cn_flipflop
//   clr         synchronous clear of counters, last_run and comp_err
//   rise_cnt    saturating count of 0->1 transitions
//   fall_cnt    saturating count of 1->0 transitions
//   run_len     saturating length of the current run in valid samples
//   last_run    length of the most recently completed run
//   edge_pulse  one-cycle pulse per transition
//   comp_err    sticky flag: a sample had q_in == qbar_in
//   stuck       run_len >= STUCK_LIMIT
//   level_st    FSM state: INIT=00, LOW=01, HIGH=10
module cn_q_monitor #(
  parameter int CNT_W       = 8,
  parameter int STUCK_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_in,
  input  logic             qbar_in,
  input  logic             clr,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic [CNT_W-1:0] run_len,
  output logic [CNT_W-1:0] last_run,
  output logic             edge_pulse,
  output logic             comp_err,
  output logic             stuck,
  output logic [1:0]       level_st
);

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_LOW  = 2'b01,
    ST_HIGH = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STUCK_LIMIT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rise_d, fall_d, run_d, last_d;
  logic             edge_d, err_d, stuck_d;
  logic             valid;

  assign valid = (q_in != qbar_in);

  always_comb begin
    state_d = state_q;
    rise_d  = rise_cnt;
    fall_d  = fall_cnt;
    run_d   = run_len;
    last_d  = last_run;
    edge_d  = 1'b0;
    err_d   = comp_err;

    if (!valid) begin
      err_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          state_d = q_in ? ST_HIGH : ST_LOW;
          run_d   = ONE;
        end
        ST_LOW: begin
          if (q_in) begin
            state_d = ST_HIGH;
            last_d  = run_len;
            run_d   = ONE;
            edge_d  = 1'b1;
            if (rise_cnt != CNT_MAX) rise_d = rise_cnt + ONE;
          end else if (run_len != CNT_MAX) begin
            run_d = run_len + ONE;
          end
        end
        ST_HIGH: begin
          if (!q_in) begin
            state_d = ST_LOW;
            last_d  = run_len;
            run_d   = ONE;
            edge_d  = 1'b1;
            if (fall_cnt != CNT_MAX) fall_d = fall_cnt + ONE;
          end else if (run_len != CNT_MAX) begin
            run_d = run_len + ONE;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end

    // clr zeroes the counters after the transition update; a coincident
    // invalid sample still sets comp_err (set wins over clear).
    if (clr) begin
      rise_d = '0;
      fall_d = '0;
      last_d = '0;
      if (valid) err_d = 1'b0;
    end

    stuck_d = (run_d >= LIMIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      rise_cnt   <= '0;
      fall_cnt   <= '0;
      run_len    <= '0;
      last_run   <= '0;
      edge_pulse <= 1'b0;
      comp_err   <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rise_cnt   <= rise_d;
      fall_cnt   <= fall_d;
      run_len    <= run_d;
      last_run   <= last_d;
      edge_pulse <= edge_d;
      comp_err   <= err_d;
      stuck      <= stuck_d;
    end
  end

  assign level_st = state_q;

endmodule

// File: doc/cn_q_monitor.md
# cn_q_monitor

Output monitor placed directly downstream of `cn_flipflop`. It samples the flip-flop's `q`/`qbar` pair every clock, checks that the pair is complementary, tracks the current output level with a three-state FSM, and counts rising and falling transitions. It also measures run lengths and flags a stuck output. Its results feed bench checkers and on-chip status registers.

## Interface
- `CNT_W`, default 8: width of the transition counters and the run-length registers.
- `STUCK_LIMIT`, default 16: run length in samples at which `stuck` asserts. Legal range is 2..2^CNT_W-1.

Ports:
- `clk` in 1: the single clock; all logic updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `q_in` in 1: the `q` output of `cn_flipflop`.
- `qbar_in` in 1: the `qbar` output of `cn_flipflop`.
- `clr` in 1: synchronous clear of the counters and the sticky error.
- `rise_cnt` out CNT_W: number of 0->1 transitions; saturates.
- `fall_cnt` out CNT_W: number of 1->0 transitions; saturates.
- `run_len` out CNT_W: length of the current run in valid samples; saturates.
- `last_run` out CNT_W: length of the most recently completed run.
- `edge_pulse` out 1: one-cycle pulse for each detected transition.
- `comp_err` out 1: sticky flag, set when a sample has `q_in == qbar_in`.
- `stuck` out 1: high while `run_len >= STUCK_LIMIT`.
- `level_st` out 2: FSM state, encoded INIT=00, LOW=01, HIGH=10.

## Operation
- **Sampling.** Each rising edge samples `q_in`/`qbar_in`.
  - A sample is valid when `q_in != qbar_in`.
  - The sampled level is `q_in`.
- **FSM.**
  - INIT, valid sample: go to LOW or HIGH per the level. `run_len` = 1. No edge is counted.
  - LOW, valid sample of 1: go to HIGH and count a rise.
  - HIGH, valid sample of 0: go to LOW and count a fall.
  - LOW or HIGH, valid sample at the same level: stay, `run_len` += 1 (saturating).
  - Invalid sample, any state: set `comp_err`. State, `run_len` and counters hold. `edge_pulse` = 0.
- **On a transition.**
  - `last_run` <= current `run_len`.
  - `run_len` <= 1.
  - `rise_cnt` or `fall_cnt` += 1 (saturating at 2^CNT_W-1).
  - `edge_pulse` = 1.
- **All counters saturate.** They never wrap.
- **stuck.** Registered as `run_len >= STUCK_LIMIT`, evaluated on the post-update `run_len`. It clears on the cycle the transition registers.
- **clr.**
  - Zeroes `rise_cnt`, `fall_cnt`, `last_run` and `comp_err`.
  - Does not affect the FSM, `run_len`, `stuck` or `edge_pulse`.
  - If `clr` coincides with a transition, the counters and `last_run` read 0. The FSM, `run_len` and `edge_pulse` still update.
  - If `clr` coincides with an invalid sample, `comp_err` reads 1: the set wins over the clear.
- **Reset.** `rst_n` = 0 at an edge forces every output to 0 and the FSM to INIT, overriding `clr` and the sample. The first valid sample after reset is treated as INIT, so it produces no edge.

## Timing
- All outputs are registered. Latency is 1 cycle: the sample taken at edge k is reflected in the outputs after edge k.
- `edge_pulse` is high for exactly one cycle per transition. Back-to-back toggles give back-to-back pulses.
- `q_in`/`qbar_in` must be stable around the sampling edge. They come synchronously from `cn_flipflop` on the same `clk`, so no synchronizer is instantiated.
- The reset value of every output is 0, including `level_st` = INIT.

## Test plan
All scenarios use `CNT_W` = 4 and `STUCK_LIMIT` = 4.

1. **Reset.** Hold `rst_n` = 0 for 3 edges while `q` toggles. Required: all outputs 0 and `level_st` = 00. Release with `q` = 1: `level_st` = 10, `run_len` = 1, `rise_cnt` = 0, no `edge_pulse`.
2. **Toggle.** Apply `q` = 0,1,0,1,0,1,0,1 with `qbar = ~q`. Required: `rise_cnt` = 4, `fall_cnt` = 3, `last_run` = 1, 7 consecutive `edge_pulse` cycles.
3. **Stuck.** After LOW, hold `q` = 1 for 6 samples, then drop to 0. Required:
   - `stuck` rises after the 4th high sample.
   - At the fall: `last_run` = 6, `stuck` = 0, `run_len` = 1.
4. **Complementary error.** Inject `q` = `qbar` = 1 for 1 sample mid-HIGH with `run_len` = 2. Required: `comp_err` = 1 stays set, `run_len` stays 2, no edge, state stays HIGH. A later `clr` clears it.
5. **Saturation.** Apply 20 rise/fall pairs. Required: `rise_cnt` = `fall_cnt` = 15, no wrap to 0. Hold level for 20 samples: `run_len` = 15.
6. **Simultaneous events.**
   - `clr` with a rise: `rise_cnt` = 0, `last_run` = 0, `edge_pulse` = 1, `level_st` = 10.
   - `rst_n` low mid-run with `run_len` = 3: all outputs 0; the next sample re-enters via INIT.
